// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer and its matching SIPO receiver.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  // Bit-counter width for a word of w bits; guarded so a degenerate width still yields one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter_en.sv
// Up-counter with clear and enable; wraps to zero after reaching LAST and flags that value.
module bit_counter_en #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LAST  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             terminal_c
);

  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(LAST);

  assign terminal_c = (count == LAST_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= terminal_c ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready, emits one bit per shift_en edge.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned BITWIDTH  = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                shift_en,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                frame_start,
  output logic                busy
);

  localparam int unsigned CW = cnt_width(BITWIDTH);

  state_t              state, state_n;
  logic [BITWIDTH-1:0] sr, sr_n;
  logic                ser_out_n, ser_valid_n, frame_start_n, in_ready_n;
  logic                cnt_clear_c, cnt_en_c, cnt_terminal_c;
  logic [CW-1:0]       cnt;

  bit_counter_en #(
    .WIDTH (CW),
    .LAST  (BITWIDTH - 1)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear_c),
    .en         (cnt_en_c),
    .count      (cnt),
    .terminal_c (cnt_terminal_c)
  );

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      ser_out     <= ser_out_n;
      ser_valid   <= ser_valid_n;
      frame_start <= frame_start_n;
      in_ready    <= in_ready_n;
    end
  end

  // Next-state logic; ser_out holds between bits, ser_valid/frame_start are single-cycle pulses.
  always_comb begin
    state_n       = state;
    sr_n          = sr;
    ser_out_n     = ser_out;
    ser_valid_n   = 1'b0;
    frame_start_n = 1'b0;
    in_ready_n    = in_ready;
    cnt_clear_c   = 1'b0;
    cnt_en_c      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sr_n        = in_data;
          cnt_clear_c = 1'b1;
          in_ready_n  = 1'b0;
          state_n     = SHIFT;
        end else begin
          in_ready_n = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (MSB_FIRST == BIT_ORDER_MSB_FIRST) begin
            ser_out_n = sr[BITWIDTH-1];
            sr_n      = {sr[BITWIDTH-2:0], 1'b0};
          end else begin
            ser_out_n = sr[0];
            sr_n      = {1'b0, sr[BITWIDTH-1:1]};
          end
          ser_valid_n   = 1'b1;
          frame_start_n = (cnt == '0);
          cnt_en_c      = 1'b1;
          if (cnt_terminal_c) begin
            state_n    = IDLE;
            in_ready_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a bit-queue reference model.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         shift_en;
  logic [W-1:0] in_data;

  logic m_ready, m_out, m_valid, m_fs, m_busy;
  logic l_ready, l_out, l_valid, l_fs, l_busy;

  piso_serializer #(.BITWIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ready), .in_data(in_data),
    .shift_en(shift_en), .ser_out(m_out), .ser_valid(m_valid), .frame_start(m_fs), .busy(m_busy)
  );

  piso_serializer #(.BITWIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_ready), .in_data(in_data),
    .shift_en(shift_en), .ser_out(l_out), .ser_valid(l_valid), .frame_start(l_fs), .busy(l_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pending bits of the current word in transmit order, one queue per bit order.
  bit qm[$];
  bit ql[$];
  bit exp_ready, exp_out_m, exp_out_l, exp_valid, exp_fs;

  logic [W-1:0] bp_words [3];

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qm.delete();
    ql.delete();
    exp_ready = 1'b0;
    exp_out_m = 1'b0;
    exp_out_l = 1'b0;
    exp_valid = 1'b0;
    exp_fs    = 1'b0;
  endtask

  task automatic model_edge();
    exp_valid = 1'b0;
    exp_fs    = 1'b0;
    if (qm.size() == 0) begin
      if (in_valid && exp_ready) begin
        for (int i = W - 1; i >= 0; i--) qm.push_back(in_data[i]);
        for (int i = 0; i < W; i++) ql.push_back(in_data[i]);
        exp_ready = 1'b0;
      end else begin
        exp_ready = 1'b1;
      end
    end else if (shift_en) begin
      exp_fs    = (qm.size() == W);
      exp_out_m = qm.pop_front();
      exp_out_l = ql.pop_front();
      exp_valid = 1'b1;
      if (qm.size() == 0) exp_ready = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " m.in_ready"},    m_ready, exp_ready);
    chk({tag, " m.ser_out"},     m_out,   exp_out_m);
    chk({tag, " m.ser_valid"},   m_valid, exp_valid);
    chk({tag, " m.frame_start"}, m_fs,    exp_fs);
    chk({tag, " m.busy"},        m_busy,  qm.size() != 0);
    chk({tag, " l.in_ready"},    l_ready, exp_ready);
    chk({tag, " l.ser_out"},     l_out,   exp_out_l);
    chk({tag, " l.ser_valid"},   l_valid, exp_valid);
    chk({tag, " l.frame_start"}, l_fs,    exp_fs);
    chk({tag, " l.busy"},        l_busy,  ql.size() != 0);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bp_words[0] = 8'h81;
    bp_words[1] = 8'h7E;
    bp_words[2] = 8'h55;

    // Power-on reset: outputs must be at reset values before any clock edge.
    rst      = 1'b1;
    in_valid = 1'b0;
    shift_en = 1'b0;
    in_data  = '0;
    model_reset();
    #3;
    check_all("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("release");

    // 0x0F with shift_en constantly high, including on the accept edge.
    shift_en = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h0F;
    step("accept_0f");
    in_valid = 1'b0;
    in_data  = 8'hFF;
    for (int i = 0; i < W + 3; i++) step("word_0f");

    // 0xA5 with shift_en every third cycle.
    shift_en = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step("accept_a5");
    in_valid = 1'b0;
    for (int c = 0; c < 3 * W; c++) begin
      shift_en = (c % 3 == 2);
      step("word_a5");
    end
    shift_en = 1'b1;
    step("idle_pulse");

    // Backpressure: in_valid held with in_data toggling, back-to-back frames.
    in_valid = 1'b1;
    for (int c = 0; c < 4 * (W + 1); c++) begin
      in_data = bp_words[c % 3];
      step("backpressure");
    end

    // Asynchronous reset three bits into 0xFF.
    in_valid = 1'b0;
    step("pre_ff");
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step("accept_ff");
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("word_ff");
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b0;
    step("rst_release");
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step("accept_3c");
    in_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) step("word_3c");

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      shift_en = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
